// File: rtl/kernel_mem_loader_pkg.sv
// Shared kernel-memory types: one complex coefficient and the 2x4 half-block written per memory access.
// Pure type definitions; no timing or flow-control behaviour lives here.
package kernel_mem_loader_pkg;

  typedef struct packed {
    logic signed [31:0] r;
    logic signed [31:0] i;
  } complex_t;

  typedef complex_t [0:1][0:3] kernel_half_t;

endpackage

// File: rtl/kernel_mem_loader.sv
// Packs a row-major coefficient stream into 2x4 half-blocks; one registered write the cycle after each 8th beat.
// Ready is high for the whole LOAD state (no internal backpressure); s_valid gaps simply stall the beat counter.
module kernel_mem_loader
  import kernel_mem_loader_pkg::*;
#(
  parameter int KERNEL_MEM_DEPTH_BITS = 9
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [KERNEL_MEM_DEPTH_BITS-1:0] base_address,
  input  logic [KERNEL_MEM_DEPTH_BITS:0]   num_kernels,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  complex_t                         s_data,
  output logic                             busy,
  output logic                             done,
  output logic                             mem_we,
  output logic [KERNEL_MEM_DEPTH_BITS-1:0] mem_write_address,
  output logic                             mem_select,
  output kernel_half_t                     mem_in
);

  localparam int W = KERNEL_MEM_DEPTH_BITS;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] LAST = 2'd2;

  logic [1:0]   state;
  logic [W-1:0] base_q;
  logic [W:0]   num_q;
  logic [W:0]   kcnt;
  logic [2:0]   beat;
  logic         half;
  kernel_half_t stage;
  kernel_half_t packed_half;
  logic         accept;
  logic         final_half;

  assign accept     = (state == LOAD) && s_valid;
  assign final_half = half && (kcnt == num_q - 1'b1);
  assign s_ready    = (state == LOAD);
  assign busy       = (state != IDLE);

  // Beat 7 bypasses staging so the half can be written the very next cycle.
  always_comb begin
    packed_half       = stage;
    packed_half[1][3] = s_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      base_q            <= '0;
      num_q             <= '0;
      kcnt              <= '0;
      beat              <= '0;
      half              <= 1'b0;
      stage             <= '0;
      done              <= 1'b0;
      mem_we            <= 1'b0;
      mem_write_address <= '0;
      mem_select        <= 1'b0;
      mem_in            <= '0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_address;
            num_q  <= num_kernels;
            kcnt   <= '0;
            beat   <= '0;
            half   <= 1'b0;
            if (num_kernels == '0) begin
              state <= LAST;
              done  <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            stage[beat[2]][beat[1:0]] <= s_data;
            beat                      <= beat + 3'd1;
            if (beat == 3'd7) begin
              mem_in            <= packed_half;
              mem_we            <= 1'b1;
              mem_select        <= half;
              mem_write_address <= base_q + kcnt[W-1:0];
              half              <= ~half;
              if (half) begin
                kcnt <= kcnt + 1'b1;
              end
              if (final_half) begin
                state <= LAST;
                done  <= 1'b1;
              end
            end
          end
        end
        LAST:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
